// File: rtl/leading_zero_shift_gen_pkg.sv
// rtl/leading_zero_shift_gen_pkg.sv - shared types and elaboration helpers for the leading-zero shift generator
package fpu_lzd_pkg;

  typedef struct packed {
    logic [1:0] count;
    logic       zero;
  } lzd_grp_t;

  // Number of 4-bit groups after zero-padding the mantissa at its LSB end
  function automatic int lzd_num_groups(input int swr);
    return (swr + 3) / 4;
  endfunction

  // The shift field must be able to represent 0..swr
  function automatic bit lzd_ewr_ok(input int swr, input int ewr);
    return (ewr < 31) && ((1 << ewr) >= (swr + 1));
  endfunction

endpackage

// File: rtl/leading_zero_shift_gen_lzc_group4.sv
// rtl/leading_zero_shift_gen_lzc_group4.sv - combinational 4-bit leading-zero count with all-zero flag
module lzc_group4
  import fpu_lzd_pkg::*;
(
  input  logic [3:0] nib_i,
  output lzd_grp_t   res_o
);

  always_comb begin
    res_o.zero = (nib_i == 4'b0000);
    casez (nib_i)
      4'b1???: res_o.count = 2'd0;
      4'b01??: res_o.count = 2'd1;
      4'b001?: res_o.count = 2'd2;
      default: res_o.count = 2'd3;
    endcase
  end

endmodule

// File: rtl/leading_zero_shift_gen.sv
// rtl/leading_zero_shift_gen.sv - two-stage leading-zero count feeding the normalization shifter
// Optional leading-one bit index output enabled by LZSG_LEAD_POS_EN.
module leading_zero_shift_gen
  import fpu_lzd_pkg::*;
#(
  parameter int SWR = 26,
  parameter int EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  output logic           ready_o,
  input  logic [SWR-1:0] Data_i,
  input  logic           ready_i,
  output logic           valid_o,
  output logic [EWR-1:0] Shift_Value_o,
`ifdef LZSG_LEAD_POS_EN
  output logic [EWR-1:0] Lead_Pos_o,
`endif
  output logic           Zero_o
);

  localparam int NG   = lzd_num_groups(SWR);
  localparam int PADW = NG * 4;
  localparam int CW   = EWR + 1;

  if (!lzd_ewr_ok(SWR, EWR)) begin : g_param_err
    $error("leading_zero_shift_gen: EWR too narrow for SWR");
  end

  logic                advance;
  logic [PADW-1:0]     data_pad;
  lzd_grp_t [NG-1:0]   grp_d;
  lzd_grp_t [NG-1:0]   s1_grp_q;
  logic                s1_valid_q;
  logic [CW-1:0]       cnt_d;
  logic                zero_d;
  logic                valid_q;
  logic [EWR-1:0]      shift_q;
  logic                zero_q;

  assign advance = !valid_q || ready_i;
  assign ready_o = advance;

  // Padding zeros sit below the real LSB, so they can only be reached when the data is all zero
  assign data_pad = PADW'(Data_i) << (PADW - SWR);

  // Group 0 is the most significant nibble
  for (genvar g = 0; g < NG; g++) begin : g_grp
    lzc_group4 u_lzc (
      .nib_i (data_pad[PADW-1-4*g -: 4]),
      .res_o (grp_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_grp_q   <= '0;
      s1_valid_q <= 1'b0;
    end else if (advance) begin
      s1_grp_q   <= grp_d;
      s1_valid_q <= load_i;
    end
  end

  // Descending scan leaves the most significant non-zero group as the final winner
  always_comb begin
    cnt_d = CW'(SWR);
    for (int g = NG - 1; g >= 0; g--) begin
      if (!s1_grp_q[g].zero) begin
        cnt_d = CW'(4 * g) + CW'(s1_grp_q[g].count);
      end
    end
    zero_d = (cnt_d == CW'(SWR));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      shift_q <= '0;
      zero_q  <= 1'b0;
    end else if (advance) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        shift_q <= cnt_d[EWR-1:0];
        zero_q  <= zero_d;
      end
    end
  end

`ifdef LZSG_LEAD_POS_EN
  logic [EWR-1:0] lead_d;
  logic [EWR-1:0] lead_q;

  assign lead_d = zero_d ? '0 : (EWR'(SWR - 1) - cnt_d[EWR-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lead_q <= '0;
    end else if (advance && s1_valid_q) begin
      lead_q <= lead_d;
    end
  end

  assign Lead_Pos_o = lead_q;
`endif

  assign valid_o       = valid_q;
  assign Shift_Value_o = shift_q;
  assign Zero_o        = zero_q;

endmodule

// File: tb/tb_leading_zero_shift_gen.sv
// tb/tb_leading_zero_shift_gen.sv - randomized and directed checks of leading_zero_shift_gen against a bit-scan model
module tb_leading_zero_shift_gen;

  localparam int SWR = 26;
  localparam int EWR = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_i;
  logic           ready_o;
  logic [SWR-1:0] Data_i;
  logic           ready_i;
  logic           valid_o;
  logic [EWR-1:0] Shift_Value_o;
  logic           Zero_o;
`ifdef LZSG_LEAD_POS_EN
  logic [EWR-1:0] Lead_Pos_o;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [SWR-1:0] exp_q[$];
  logic           prev_stall = 1'b0;
  logic [EWR-1:0] prev_shift;
  logic           prev_zero;

  always #5 clk = ~clk;

  leading_zero_shift_gen #(.SWR(SWR), .EWR(EWR)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_i        (load_i),
    .ready_o       (ready_o),
    .Data_i        (Data_i),
    .ready_i       (ready_i),
    .valid_o       (valid_o),
    .Shift_Value_o (Shift_Value_o),
`ifdef LZSG_LEAD_POS_EN
    .Lead_Pos_o    (Lead_Pos_o),
`endif
    .Zero_o        (Zero_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: position of the first one bit scanning down from the MSB
  function automatic int ref_lzc(input logic [SWR-1:0] d);
    for (int i = SWR - 1; i >= 0; i--) begin
      if (d[i]) return SWR - 1 - i;
    end
    return SWR;
  endfunction

  task automatic step(input logic ld, input logic [SWR-1:0] d, input logic rdy, output logic acc);
    logic [SWR-1:0] e;
    int             c;
    @(negedge clk);
    load_i  = ld;
    Data_i  = d;
    ready_i = rdy;
    #1;
    if (prev_stall) begin
      check_eq("hold_valid", 32'(valid_o), 32'd1);
      check_eq("hold_shift", 32'(Shift_Value_o), 32'(prev_shift));
      check_eq("hold_zero", 32'(Zero_o), 32'(prev_zero));
    end
    check_eq("ready_rule", 32'(ready_o), 32'(!valid_o || ready_i));
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = ref_lzc(e);
        check_eq("shift", 32'(Shift_Value_o), 32'(c));
        check_eq("zero", 32'(Zero_o), 32'(c == SWR));
`ifdef LZSG_LEAD_POS_EN
        check_eq("lead_pos", 32'(Lead_Pos_o), (c == SWR) ? 32'd0 : 32'(SWR - 1 - c));
`endif
      end
    end
    acc = load_i && ready_o;
    if (acc) exp_q.push_back(d);
    prev_stall = valid_o && !ready_i;
    prev_shift = Shift_Value_o;
    prev_zero  = Zero_o;
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1'b0, '0, 1'b1, a);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic           a;
    logic           pend;
    logic           ld;
    logic [SWR-1:0] d;
    logic [SWR-1:0] tmp;
    logic [3:0]     seen;

    rst = 1'b0; load_i = 1'b0; ready_i = 1'b1; Data_i = '0;
    #1;
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_shift", 32'(Shift_Value_o), 32'd0);
    check_eq("rst_zero", 32'(Zero_o), 32'd0);
    check_eq("rst_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Latency: accepted at the edge after step 1, visible after the following edge
    step(1'b1, 26'h2000000, 1'b1, a);
    check_eq("lat_accept", 32'(a), 32'd1);
    step(1'b0, '0, 1'b1, a);
    check_eq("lat_v0", 32'(valid_o), 32'd0);
    step(1'b0, '0, 1'b1, a);
    check_eq("lat_v1", 32'(valid_o), 32'd1);
    check_eq("lat_shift", 32'(Shift_Value_o), 32'd0);

    step(1'b1, 26'h0000001, 1'b1, a);
    step(1'b1, 26'h0000000, 1'b1, a);
    step(1'b1, 26'h0040000, 1'b1, a);
    drain();

    // Back-to-back: three consecutive valid cycles then a gap
    step(1'b1, 26'h0800000, 1'b1, a);
    step(1'b1, 26'h0010000, 1'b1, a);
    step(1'b1, 26'h0000100, 1'b1, a);
    seen[0] = valid_o;
    step(1'b0, '0, 1'b1, a);
    seen[1] = valid_o;
    step(1'b0, '0, 1'b1, a);
    seen[2] = valid_o;
    step(1'b0, '0, 1'b1, a);
    seen[3] = valid_o;
    check_eq("b2b_valid_pattern", 32'(seen), 32'b0111);

    // Stall with a continuously offered input
    step(1'b1, 26'h1000000, 1'b0, a);
    step(1'b1, 26'h0000400, 1'b0, a);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 26'h0000003, 1'b0, a);
      check_eq("stall_ready", 32'(ready_o), 32'd0);
    end
    step(1'b1, 26'h0000003, 1'b1, a);
    check_eq("unstall_accept", 32'(a), 32'd1);
    drain();

    // Reset with two results in flight
    step(1'b1, 26'h0000001, 1'b1, a);
    step(1'b1, 26'h0000002, 1'b1, a);
    @(posedge clk);
    #2;
    load_i = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
    check_eq("mid_rst_shift", 32'(Shift_Value_o), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1, a);
      check_eq("post_rst_idle", 32'(valid_o), 32'd0);
    end

    // Randomized traffic with a source that holds unaccepted inputs
    pend = 1'b0;
    ld = 1'b0;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        ld  = ($urandom_range(0, 3) != 0);
        tmp = SWR'($urandom) | (SWR'(1) << (SWR - 1));
        d   = tmp >> $urandom_range(0, SWR);
      end
      step(ld, d, 1'($urandom_range(0, 2) != 0), a);
      pend = ld && !a;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
